// File: rtl/cdr_pkg.sv
// rtl/cdr_pkg.sv - shared types and helpers for the oversampling CDR
package cdr_pkg;

  typedef enum logic {
    ACQ    = 1'b0,
    LOCKED = 1'b1
  } lockState_t;

  // Bits needed to hold values 0..v-1 (never less than one bit)
  function automatic int clog2(input int v);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  // A transition is in window when the next phase sits within tol of the bit boundary
  function automatic logic edgeGood(input int d, input int osr, input int tol);
    return (d <= tol) || (d >= osr - tol);
  endfunction

endpackage

// File: rtl/cdr_lock_det.sv
// rtl/cdr_lock_det.sv - transition quality counters and ACQ/LOCKED lock state machine
module cdr_lock_det
  import cdr_pkg::*;
#(
  parameter int LOCK_CNT = 16,
  parameter int MAX_RUN  = 32
) (
  input  logic i_clk,
  input  logic i_res_n,
  input  logic ts,
  input  logic good,
  input  logic wrap,
  output logic o_Lock,
  output logic o_EdgeErr
);

  localparam int GW = clog2(LOCK_CNT + 1);
  localparam int RW = clog2(MAX_RUN + 1);
  localparam logic [GW-1:0] GOOD_MAX = GW'(LOCK_CNT);
  localparam logic [GW-1:0] GOOD_PRE = GW'(LOCK_CNT - 1);
  localparam logic [RW-1:0] RUN_MAX  = RW'(MAX_RUN);

  lockState_t    rState;
  lockState_t    nextState;
  logic [GW-1:0] rGood;
  logic [RW-1:0] rRun;
  logic          rErr;
  logic          badTs;
  logic          runOut;

  assign badTs  = ts & ~good;
  assign runOut = (rRun == RUN_MAX);

  // Lock state register
  always_ff @(posedge i_clk or negedge i_res_n) begin
    if (!i_res_n) rState <= ACQ;
    else          rState <= nextState;
  end

  // Enter lock on the good transition that completes the count; leave on a bad edge or a long run
  always_comb begin
    nextState = rState;
    case (rState)
      ACQ:     if (ts && good && (rGood == GOOD_PRE)) nextState = LOCKED;
      LOCKED:  if (badTs || runOut) nextState = ACQ;
      default: nextState = ACQ;
    endcase
  end

  // Good-edge and run-length counters (both saturating) plus the registered error pulse
  always_ff @(posedge i_clk or negedge i_res_n) begin
    if (!i_res_n) begin
      rGood <= '0;
      rRun  <= '0;
      rErr  <= 1'b0;
    end else begin
      rErr <= badTs;
      if (ts)                  rRun <= '0;
      else if (wrap && !runOut) rRun <= rRun + 1'b1;
      if (rState == LOCKED) begin
        if (badTs || runOut) rGood <= '0;
      end else if (badTs) begin
        rGood <= '0;
      end else if (ts && (rGood != GOOD_MAX)) begin
        rGood <= rGood + 1'b1;
      end
    end
  end

  // Outputs follow the registered state and error flag
  always_comb begin
    o_Lock    = (rState == LOCKED);
    o_EdgeErr = rErr;
  end

endmodule

// File: rtl/cdr_os.sv
// rtl/cdr_os.sv - oversampling CDR top; CDR_MAJORITY_EN selects 3-sample majority capture
module cdr_os
  import cdr_pkg::*;
#(
  parameter int OSR         = 4,
  parameter int SYNC_STAGES = 3,
  parameter int SAMPLE_PH   = 1,
  parameter int EDGE_TOL    = 1,
  parameter int LOCK_CNT    = 16,
  parameter int MAX_RUN     = 32
) (
  input  logic i_clk,
  input  logic i_res_n,
  input  logic i_SerialData,
  output logic o_RecoveryData,
  output logic o_DataEn,
  output logic o_Lock,
  output logic o_EdgeErr
);

  localparam int PHW = clog2(OSR);
  localparam logic [PHW-1:0] PH_LAST = PHW'(OSR - 1);
`ifdef CDR_MAJORITY_EN
  localparam logic [PHW-1:0] CAP_PH = PHW'(SAMPLE_PH + 1);
`else
  localparam logic [PHW-1:0] CAP_PH = PHW'(SAMPLE_PH);
`endif

  logic [SYNC_STAGES-1:0] rSync;
  logic                   sD;
  logic                   s;
  logic                   ts;
  logic                   wrap;
  logic                   good;
  logic                   capBit;
  logic [PHW-1:0]         rPh;
  logic [PHW-1:0]         phNext;

  assign s      = rSync[SYNC_STAGES-1];
  assign ts     = s ^ sD;
  assign phNext = (rPh == PH_LAST) ? '0 : rPh + 1'b1;
  assign wrap   = ~ts & (rPh == PH_LAST);
  assign good   = edgeGood(int'(phNext), OSR, EDGE_TOL);

  // Metastability chain on the raw pin plus one extra tap for transition detection
  always_ff @(posedge i_clk or negedge i_res_n) begin
    if (!i_res_n) begin
      rSync <= '0;
      sD    <= 1'b0;
    end else begin
      rSync <= {rSync[SYNC_STAGES-2:0], i_SerialData};
      sD    <= s;
    end
  end

`ifdef CDR_MAJORITY_EN
  logic sD2;

  // Second delay tap so three consecutive samples are available at capture time
  always_ff @(posedge i_clk or negedge i_res_n) begin
    if (!i_res_n) sD2 <= 1'b0;
    else          sD2 <= sD;
  end

  assign capBit = (s & sD) | (s & sD2) | (sD & sD2);
`else
  assign capBit = s;
`endif

  // Phase counter: realigns to every transition, free-runs through constant runs
  always_ff @(posedge i_clk or negedge i_res_n) begin
    if (!i_res_n)  rPh <= '0;
    else if (ts)   rPh <= '0;
    else           rPh <= phNext;
  end

  // Capture on the registered phase so a same-cycle transition cannot suppress the strobe
  always_ff @(posedge i_clk or negedge i_res_n) begin
    if (!i_res_n) begin
      o_RecoveryData <= 1'b0;
      o_DataEn       <= 1'b0;
    end else if (rPh == CAP_PH) begin
      o_RecoveryData <= capBit;
      o_DataEn       <= 1'b1;
    end else begin
      o_DataEn       <= 1'b0;
    end
  end

  cdr_lock_det #(
    .LOCK_CNT (LOCK_CNT),
    .MAX_RUN  (MAX_RUN)
  ) u_lock (
    .i_clk     (i_clk),
    .i_res_n   (i_res_n),
    .ts        (ts),
    .good      (good),
    .wrap      (wrap),
    .o_Lock    (o_Lock),
    .o_EdgeErr (o_EdgeErr)
  );

endmodule

// File: tb/tb_cdr_os.sv
// tb/tb_cdr_os.sv - directed table-driven bench for cdr_os (OSR=4, SAMPLE_PH=1)
module tb_cdr_os;

  logic i_clk = 1'b0;
  logic i_res_n = 1'b0;
  logic i_SerialData = 1'b0;
  logic o_RecoveryData;
  logic o_DataEn;
  logic o_Lock;
  logic o_EdgeErr;

`ifdef CDR_MAJORITY_EN
  localparam int CAP_DLY = 3;
`else
  localparam int CAP_DLY = 2;
`endif

  cdr_os dut (
    .i_clk          (i_clk),
    .i_res_n        (i_res_n),
    .i_SerialData   (i_SerialData),
    .o_RecoveryData (o_RecoveryData),
    .o_DataEn       (o_DataEn),
    .o_Lock         (o_Lock),
    .o_EdgeErr      (o_EdgeErr)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic v;
    logic expBit;
    logic lockMid;
    logic lockEnd;
  } vec_t;

  vec_t vecs[30];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   errCnt = 0;
  logic rxQ[$];
  int   stbCyc[$];

  always @(posedge i_clk) cyc <= cyc + 1;

  always @(negedge i_clk) begin
    if (i_res_n) begin
      if (o_DataEn) begin
        rxQ.push_back(o_RecoveryData);
        stbCyc.push_back(cyc);
      end
      if (o_EdgeErr) errCnt++;
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic drive(input logic v, input int n);
    i_SerialData = v;
    repeat (n) @(posedge i_clk);
    #1;
  endtask

  task automatic doReset();
    i_res_n = 1'b0;
    i_SerialData = 1'b0;
    #1;
    check("rst_immediate", {28'd0, o_RecoveryData, o_DataEn, o_Lock, o_EdgeErr}, 0);
    rxQ.delete();
    stbCyc.delete();
    repeat (3) @(posedge i_clk);
    #1 i_res_n = 1'b1;
  endtask

  task automatic runGroup(input int lo, input int hi);
    logic expQ[$];
    int   errBase;
    int   badGap;
    doReset();
    errBase = errCnt;
    expQ.push_back(1'b0);
    for (int i = lo; i <= hi; i++) begin
      i_SerialData = vecs[i].v;
      repeat (3) @(posedge i_clk);
      #1 check($sformatf("lock_mid[%0d]", i), o_Lock, vecs[i].lockMid);
      @(posedge i_clk);
      #1 check($sformatf("lock_end[%0d]", i), o_Lock, vecs[i].lockEnd);
      expQ.push_back(vecs[i].expBit);
    end
    repeat (4) @(posedge i_clk);
    #1;
    check("strobe_count", rxQ.size(), expQ.size());
    for (int i = 0; i < expQ.size() && i < rxQ.size(); i++)
      check($sformatf("rx_bit[%0d]", i), rxQ[i], expQ[i]);
    badGap = 0;
    for (int i = 1; i < stbCyc.size(); i++)
      if (stbCyc[i] - stbCyc[i-1] != 4) badGap++;
    check("strobe_spacing", badGap, 0);
    check("no_edge_err", errCnt - errBase, 0);
  endtask

  initial begin
    int errBase;
    int base;
    int badGap;
    int badVal;

    for (int i = 0; i < 10; i++) begin
      vecs[i].v = (i >= 2) ? ((8'hA5 >> (9 - i)) & 1) : 1'b0;
      vecs[i].expBit = vecs[i].v;
      vecs[i].lockMid = 1'b0;
      vecs[i].lockEnd = 1'b0;
    end
    for (int i = 10; i < 30; i++) begin
      int k;
      k = i - 11;
      vecs[i].v = (k >= 1) ? logic'(k % 2) : 1'b0;
      vecs[i].expBit = vecs[i].v;
      vecs[i].lockMid = (k >= 17);
      vecs[i].lockEnd = (k >= 16);
    end

    // reset held while the input toggles
    for (int i = 0; i < 6; i++) begin
      i_SerialData = ~i_SerialData;
      @(posedge i_clk);
      #1 check($sformatf("reset_outs[%0d]", i), {28'd0, o_RecoveryData, o_DataEn, o_Lock, o_EdgeErr}, 0);
    end
    i_SerialData = 1'b0;
    #1 i_res_n = 1'b1;
    for (int i = 1; i < CAP_DLY; i++) begin
      @(posedge i_clk);
      #1 check("no_early_strobe", o_DataEn, 0);
    end
    @(posedge i_clk);
    #1 check("first_strobe", o_DataEn, 1);

    // 0xA5 stream, then alternating bits to lock (twice, second reset hits while locked)
    runGroup(0, 9);
    runGroup(10, 29);
    runGroup(10, 29);

    // early by one clock tolerated, early by two flagged and unlocks
    errBase = errCnt;
    drive(1'b1, 3);
    drive(1'b0, 4);
    check("early1_err", o_EdgeErr, 0);
    check("early1_lock", o_Lock, 1);
    drive(1'b1, 2);
    check("pre_early2_lock", o_Lock, 1);
    drive(1'b0, 4);
    check("early2_err", o_EdgeErr, 1);
    check("early2_lock", o_Lock, 0);
    drive(1'b0, 1);
    check("err_one_clk", o_EdgeErr, 0);
    drive(1'b0, 4);
    check("early2_err_count", errCnt - errBase, 1);

    // lock again, then a long constant run
    runGroup(10, 29);
    base = stbCyc.size();
    errBase = errCnt;
    drive(1'b0, 124);
    check("run32_lock_held", o_Lock, 1);
    drive(1'b0, 1);
    check("run32_lock_drop", o_Lock, 0);
    drive(1'b0, 31);
    check("run_strobes", stbCyc.size() - base, 39);
    badGap = 0;
    badVal = 0;
    for (int i = base; i < stbCyc.size(); i++) begin
      if (stbCyc[i] - stbCyc[i-1] != 4) badGap++;
      if (rxQ[i] !== 1'b0) badVal++;
    end
    check("run_spacing", badGap, 0);
    check("run_values", badVal, 0);
    check("run_no_err", errCnt - errBase, 0);

    // single-clock glitch landing on the sample phase
    rxQ.delete();
    stbCyc.delete();
    drive(1'b0, 2);
    drive(1'b1, 1);
    drive(1'b0, 8);
`ifdef CDR_MAJORITY_EN
    check("glitch_count", rxQ.size(), 2);
    if (rxQ.size() == 2) begin
      check("glitch_bit0", rxQ[0], 0);
      check("glitch_bit1", rxQ[1], 0);
    end
`else
    check("glitch_count", rxQ.size(), 3);
    if (rxQ.size() == 3) begin
      check("glitch_bit0", rxQ[0], 0);
      check("glitch_bit1", rxQ[1], 1);
      check("glitch_bit2", rxQ[2], 0);
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
